lsu_subword_bridge: RTL and testbench
=====================================

# lsu_subword_bridge

Load/store bridge for the MEM stage, between the EX/MEM pipeline register and the word-addressed data memory. Converts byte addresses to word indices, extracts and sign/zero-extends byte and halfword loads, and performs byte/halfword stores as a two-cycle read-modify-write. While that sequence runs it stalls the pipeline.

## Interface
- MEM_WORDS, 200: number of 32-bit words in the data memory. Valid word indices are 0..MEM_WORDS-1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  MEM-stage access request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word data is taken from the low bits.
- stall  out  1  hold the pipeline; upstream keeps all req_* stable while it is 1.
- rdata  out  32  load result.
- rdata_valid  out  1  rdata is meaningful this cycle.
- misalign  out  1  misaligned access flag. Present only with LSU_MISALIGN_TRAP_EN.
- mem_addr  out  32  word index: {2'b00, req_addr[31:2]}.
- mem_wdata  out  32  memory write data.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by req_addr[1:0]. A halfword uses lanes {2,3} when req_addr[1] = 1, otherwise {0,1}.
- FSM states:
  - IDLE: services loads and word stores directly.
  - MERGE: sub-word store read cycle.
  - COMMIT: sub-word store write cycle.
- Load (any size), in IDLE:
  - mem_read = 1.
  - rdata = extracted lane(s), sign- or zero-extended per req_signed; word loads are passed through.
  - rdata_valid = 1 and stall = 0 in the same cycle.
- Word store, in IDLE: mem_write = 1, mem_wdata = req_wdata, stall = 0.
- Sub-word store:
  - IDLE with a sub-word store request: enter MERGE combinationally. mem_read = 1, stall = 1.
  - MERGE: the lane-merged word (mem_rdata with the target lanes replaced by req_wdata) is registered at the posedge; next state is COMMIT.
  - COMMIT: mem_write = 1, mem_wdata = the registered merged word, stall = 0; next state is IDLE.
  - There is no combinational path from mem_rdata to mem_wdata.
- Out of range (word index ≥ MEM_WORDS): the access is suppressed (mem_read = mem_write = 0). Loads return rdata = 0 with rdata_valid = 1. No stall.
- req_valid = 0: all mem_* enables are 0, rdata = 0, rdata_valid = 0.
- Back-to-back sub-word stores: each store takes MERGE then COMMIT. The next store's MERGE starts the cycle after COMMIT.

## Timing
- Reset values: FSM IDLE, merged-word register 0, stall 0, mem_write 0, mem_read 0, rdata 0, rdata_valid 0, misalign 0.
- Latency:
  - Loads and word stores: 0 extra cycles. The memory write lands at the end-of-cycle posedge.
  - Sub-word stores: 1 extra cycle (stall high for exactly one cycle).
- Reset asserted in MERGE or COMMIT: return to IDLE immediately. No write is issued and memory is unchanged.
- mem_write is never asserted in MERGE. mem_read is never asserted in COMMIT.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] ≠ 0, sets misalign = 1 (combinational, qualified by req_valid).
  - The access is suppressed: no mem enables, rdata = 0, no stall.
- LSU_MISALIGN_TRAP_EN undefined:
  - The misalign port is absent.
  - Low address bits are ignored: a word access ignores [1:0]; a halfword access ignores [0].

## Structure
- Shared package lsu_pkg contains:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state enum (IDLE, MERGE, COMMIT);
  - the MEM_WORDS default constant.
- Sub-module lsu_subword_align: combinational lane extract/extend for loads and lane merge for stores. The parent holds the FSM and registers.

## Test plan
- Word load from address 0x0C, with memory word 3 = 200 → rdata = 0x000000C8, rdata_valid = 1, stall = 0 in the same cycle.
- Store word 0x000080FF at 0x10, then byte load (req_signed = 1) at 0x11 → rdata = 0xFFFFFF80. The same load with req_signed = 0 → rdata = 0x00000080.
- Byte store of 0xAB at 0x0A, with word 2 = 0x00000064 → stall = 1 for one cycle, mem_write only in COMMIT; word 2 becomes 0x00AB0064.
- Halfword store of 0x1234 at 0x0E, with word 3 = 0xC8 → word 3 becomes 0x123400C8. An immediately following byte store also completes correctly.
- rst pulsed during the MERGE cycle of a byte store at 0x08 → no mem_write; word 2 is unchanged; stall = 0 and the FSM is in IDLE after reset.
- Word load at 0x09:
  - with LSU_MISALIGN_TRAP_EN → misalign = 1, mem_read = 0, rdata = 0;
  - without it → reads word 2 (0x64).

Source files
------------

// File: rtl/lsu_subword_bridge_pkg.sv
// lsu_subword_bridge shared definitions: access sizes, FSM states, memory depth.
// Optional feature macro: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MEM_WORDS_DEF = 200;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MERGE  = 2'd1,
    COMMIT = 2'd2
  } lsu_state_e;

  // Size 2'b11 behaves like a word.
  function automatic logic is_subword(
    input logic [1:0] sz
  );
    return (sz == SZ_BYTE) || (sz == SZ_HALF);
  endfunction

endpackage

// File: rtl/lsu_subword_bridge_if.sv
// MEM-stage request / data-memory bundle for lsu_subword_bridge.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds misalign).
interface lsu_subword_bridge_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output stall, rdata, rdata_valid,
`ifdef LSU_MISALIGN_TRAP_EN
    output misalign,
`endif
    output mem_addr, mem_wdata,
    output mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  stall, rdata, rdata_valid,
`ifdef LSU_MISALIGN_TRAP_EN
    input  misalign,
`endif
    input  mem_addr, mem_wdata,
    input  mem_write, mem_read
  );

endinterface

// File: rtl/lsu_subword_bridge_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; holds no state.
module lsu_subword_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  bsel;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsel = {lane_i, 3'b000};
  assign b    = rword_i[bsel +: 8];
  assign h    = lane_i[1] ? rword_i[31:16]
                          : rword_i[15:0];

  always_comb begin
    load_o  = rword_i;
    merge_o = wdata_i;
    unique case (1'b1)
      size_i == SZ_BYTE: begin
        load_o  = {{24{sign_i & b[7]}}, b};
        merge_o = rword_i;
        merge_o[bsel +: 8] = wdata_i[7:0];
      end
      size_i == SZ_HALF: begin
        load_o  = {{16{sign_i & h[15]}}, h};
        merge_o = lane_i[1]
          ? {wdata_i[15:0], rword_i[15:0]}
          : {rword_i[31:16], wdata_i[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_subword_bridge.sv
// MEM-stage load/store bridge: sub-word loads, RMW sub-word stores.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned access trap).
module lsu_subword_bridge
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input logic               clk,
  input logic               rst,
  lsu_subword_bridge_if.slave bus
);

  localparam logic [29:0] LIM = 30'(MEM_WORDS);

  lsu_state_e  state_q, state_d, st;
  logic [31:0] merged_q, merged_d;
  logic [31:0] load_w, merge_w;
  logic        in_range, mis, go, sub_st;

  lsu_subword_align u_align (
    .size_i  (bus.req_size),
    .sign_i  (bus.req_signed),
    .lane_i  (bus.req_addr[1:0]),
    .rword_i (bus.mem_rdata),
    .wdata_i (bus.req_wdata),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  assign in_range = bus.req_addr[31:2] < LIM;
  assign bus.mem_addr = {2'b00, bus.req_addr[31:2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = bus.req_valid & ~rst &
    (((bus.req_size == SZ_HALF) & bus.req_addr[0]) |
     (bus.req_size[1] & (|bus.req_addr[1:0])));
  assign bus.misalign = mis;
`else
  assign mis = 1'b0;
`endif

  assign go     = bus.req_valid & ~rst & ~mis;
  assign sub_st = go & in_range & bus.req_write &
                  is_subword(bus.req_size);

  // MERGE is the cycle a sub-word store is first seen in IDLE.
  assign st = (state_q == IDLE && sub_st) ? MERGE : state_q;

  always_comb begin
    state_d         = IDLE;
    merged_d        = merged_q;
    bus.stall       = 1'b0;
    bus.rdata       = '0;
    bus.rdata_valid = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wdata   = bus.req_wdata;
    unique case (st)
      MERGE: begin
        state_d      = COMMIT;
        merged_d     = merge_w;
        bus.mem_read = 1'b1;
        bus.stall    = 1'b1;
      end
      COMMIT: begin
        bus.mem_write = bus.req_valid & ~rst;
        bus.mem_wdata = merged_q;
      end
      default: begin
        if (go && !bus.req_write) begin
          bus.rdata_valid = 1'b1;
          if (in_range) begin
            bus.mem_read = 1'b1;
            bus.rdata    = load_w;
          end
        end else if (go && in_range) begin
          bus.mem_write = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      merged_q <= merged_d;
    end
  end

endmodule

// File: tb/tb_lsu_subword_bridge.sv
// Directed bench for lsu_subword_bridge against a behavioural memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN.
module tb_lsu_subword_bridge;
  import lsu_pkg::*;

  logic clk;
  logic rst;

  lsu_subword_bridge_if bus ();

  lsu_subword_bridge #(.MEM_WORDS(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];

  assign bus.mem_rdata = (bus.mem_addr < 32'd256)
    ? mem[bus.mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr < 32'd256)
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  typedef struct {
    string       name;
    logic        vld;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] e_rdata;
    logic        e_rv;
    logic        e_rd;
    logic        e_wr;
    logic        e_stall;
    logic        e_mis;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic wr,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr,
                       input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid  = vld;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    #1;
  endtask

  vec_t v [$];

  initial begin
    v.push_back('{"sw_w2", 1,1,SZ_WORD,0,32'h08,32'h64,
                  0,0,0,1,0,0});
    v.push_back('{"sw_w3", 1,1,SZ_WORD,0,32'h0C,32'd200,
                  0,0,0,1,0,0});
    v.push_back('{"sw_w4", 1,1,SZ_WORD,0,32'h10,32'h80FF,
                  0,0,0,1,0,0});
    v.push_back('{"sw_w199", 1,1,SZ_WORD,0,32'h31C,32'hDEADBEEF,
                  0,0,0,1,0,0});
    v.push_back('{"lw_0c", 1,0,SZ_WORD,0,32'h0C,0,
                  32'h000000C8,1,1,0,0,0});
    v.push_back('{"lb_s_11", 1,0,SZ_BYTE,1,32'h11,0,
                  32'hFFFFFF80,1,1,0,0,0});
    v.push_back('{"lbu_11", 1,0,SZ_BYTE,0,32'h11,0,
                  32'h00000080,1,1,0,0,0});
    v.push_back('{"lb_s_10", 1,0,SZ_BYTE,1,32'h10,0,
                  32'hFFFFFFFF,1,1,0,0,0});
    v.push_back('{"lh_s_10", 1,0,SZ_HALF,1,32'h10,0,
                  32'hFFFF80FF,1,1,0,0,0});
    v.push_back('{"lhu_10", 1,0,SZ_HALF,0,32'h10,0,
                  32'h000080FF,1,1,0,0,0});
    v.push_back('{"lh_s_12", 1,0,SZ_HALF,1,32'h12,0,
                  32'h00000000,1,1,0,0,0});
    v.push_back('{"lw_sz3", 1,0,2'b11,0,32'h0C,0,
                  32'h000000C8,1,1,0,0,0});
    v.push_back('{"lw_last", 1,0,SZ_WORD,0,32'h31C,0,
                  32'hDEADBEEF,1,1,0,0,0});
    v.push_back('{"lw_oor", 1,0,SZ_WORD,0,32'h320,0,
                  0,1,0,0,0,0});
    v.push_back('{"sw_oor", 1,1,SZ_WORD,0,32'h320,32'h1,
                  0,0,0,0,0,0});
    v.push_back('{"sb_oor", 1,1,SZ_BYTE,0,32'h321,32'h1,
                  0,0,0,0,0,0});
    v.push_back('{"idle", 0,0,SZ_WORD,0,32'h0C,0,
                  0,0,0,0,0,0});
`ifdef LSU_MISALIGN_TRAP_EN
    v.push_back('{"lw_09", 1,0,SZ_WORD,0,32'h09,0,
                  0,0,0,0,0,1});
    v.push_back('{"lh_11", 1,0,SZ_HALF,0,32'h11,0,
                  0,0,0,0,0,1});
`else
    v.push_back('{"lw_09", 1,0,SZ_WORD,0,32'h09,0,
                  32'h00000064,1,1,0,0,0});
    v.push_back('{"lh_11", 1,0,SZ_HALF,0,32'h11,0,
                  32'h000080FF,1,1,0,0,0});
`endif

    rst = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = SZ_BYTE;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h08;
    bus.req_wdata  = 32'h0;
    #2;
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    bus.req_valid = 1'b0;
    #1;
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rdata_valid", bus.rdata_valid, 0);
    chk("rst_merged", dut.merged_q, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("rst_misalign", bus.misalign, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    foreach (v[i]) begin
      drive(v[i].vld, v[i].wr, v[i].sz, v[i].sg,
            v[i].addr, v[i].wd);
      chk({v[i].name, "_rdata"}, bus.rdata, v[i].e_rdata);
      chk({v[i].name, "_rv"}, bus.rdata_valid, v[i].e_rv);
      chk({v[i].name, "_rd"}, bus.mem_read, v[i].e_rd);
      chk({v[i].name, "_wr"}, bus.mem_write, v[i].e_wr);
      chk({v[i].name, "_stall"}, bus.stall, v[i].e_stall);
`ifdef LSU_MISALIGN_TRAP_EN
      chk({v[i].name, "_mis"}, bus.misalign, v[i].e_mis);
`endif
      if (v[i].vld)
        chk({v[i].name, "_addr"}, bus.mem_addr,
            {2'b00, v[i].addr[31:2]});
    end

    // Byte store 0xAB at 0x0A onto word 2 = 0x64.
    drive(1, 1, SZ_BYTE, 0, 32'h0A, 32'hFFFFFFAB);
    chk("sb_m_stall", bus.stall, 1);
    chk("sb_m_rd", bus.mem_read, 1);
    chk("sb_m_wr", bus.mem_write, 0);
    drive(1, 1, SZ_BYTE, 0, 32'h0A, 32'hFFFFFFAB);
    chk("sb_c_stall", bus.stall, 0);
    chk("sb_c_wr", bus.mem_write, 1);
    chk("sb_c_rd", bus.mem_read, 0);
    chk("sb_c_wdata", bus.mem_wdata, 32'h00AB0064);
    chk("sb_c_addr", bus.mem_addr, 32'd2);
    drive(1, 0, SZ_WORD, 0, 32'h08, 0);
    chk("sb_result", bus.rdata, 32'h00AB0064);
    chk("sb_next_stall", bus.stall, 0);

    // Halfword 0x1234 at 0x0E then byte 0x5A at 0x0C.
    drive(1, 1, SZ_HALF, 0, 32'h0E, 32'hCCCC1234);
    chk("sh_m_stall", bus.stall, 1);
    chk("sh_m_wr", bus.mem_write, 0);
    drive(1, 1, SZ_HALF, 0, 32'h0E, 32'hCCCC1234);
    chk("sh_c_stall", bus.stall, 0);
    chk("sh_c_wr", bus.mem_write, 1);
    chk("sh_c_wdata", bus.mem_wdata, 32'h123400C8);
    drive(1, 1, SZ_BYTE, 0, 32'h0C, 32'h0000005A);
    chk("sb2_m_stall", bus.stall, 1);
    chk("sb2_m_rd", bus.mem_read, 1);
    chk("sb2_m_wr", bus.mem_write, 0);
    drive(1, 1, SZ_BYTE, 0, 32'h0C, 32'h0000005A);
    chk("sb2_c_wr", bus.mem_write, 1);
    chk("sb2_c_rd", bus.mem_read, 0);
    chk("sb2_c_wdata", bus.mem_wdata, 32'h1234005A);
    drive(1, 0, SZ_WORD, 0, 32'h0C, 0);
    chk("sh_sb_result", bus.rdata, 32'h1234005A);

    // Reset pulsed during the MERGE cycle of a byte store.
    drive(1, 1, SZ_BYTE, 0, 32'h08, 32'h77);
    chk("rm_m_stall", bus.stall, 1);
    rst = 1'b1;
    #1;
    chk("rm_r_stall", bus.stall, 0);
    chk("rm_r_wr", bus.mem_write, 0);
    chk("rm_r_rd", bus.mem_read, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("rm_stall", bus.stall, 0);
    chk("rm_wr", bus.mem_write, 0);
    chk("rm_state", dut.state_q, IDLE);
    chk("rm_merged", dut.merged_q, 0);
    drive(1, 0, SZ_WORD, 0, 32'h08, 0);
    chk("rm_word2", bus.rdata, 32'h00AB0064);
    drive(0, 0, SZ_WORD, 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
